spart_receive: RTL
==================

Name: spart_receive

Overview:
- Serial receive front end of the SPART. It converts the asynchronous RxD line into parallel bytes for the SPART receive buffer logic.
- Frame format is 8N1, LSB first, oversampled at OVERSAMPLE ticks per bit. Ticks come from the shared baud-rate enable: with the 0xA2 reload counter, 8 ticks per bit at 38400 baud.
- Outputs are a byte plus a one-cycle RDA strobe, and a framing-error strobe for diagnostics.

Parameters:
- OVERSAMPLE, 8, Enable ticks per bit period; must be even and ≥4.
- DATA_BITS, 8, data bits per frame.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- Enable  input  1  baud tick, one clk wide; all bit timing advances only on cycles with Enable=1.
- RxD  input  1  asynchronous serial line; idle high.
- DATA  output  DATA_BITS  last correctly framed byte; held until the next good frame.
- RDA  output  1  one-cycle pulse: DATA was just updated.
- FE  output  1  one-cycle pulse: stop bit sampled low.

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset: state=IDLE, counters=0, shift register=0, DATA=0, RDA=0, FE=0, synchroniser flops=1. Reset mid-frame discards the partial byte; no RDA or FE is produced for that frame.
- Synchroniser: RxD passes through 2 flops on every clk, independent of Enable, giving rx_s. All decisions use rx_s.
- Tick counter cnt is log2(OVERSAMPLE) bits wide. Bit index idx counts 0..DATA_BITS-1.
- States:
  - IDLE: on a tick with rx_s=0 → START, cnt=0. Treat this tick as tick 0 of the start bit.
  - START: on each tick cnt++. On the tick where cnt reaches OVERSAMPLE/2-1 (mid start bit):
    - rx_s=1 → IDLE (glitch rejected, no output).
    - rx_s=0 → DATA, cnt=0, idx=0.
  - DATA: on each tick cnt++. On the tick where cnt reaches OVERSAMPLE-1 (mid bit):
    - shift in rx_s at the MSB, shifting right, so the first bit received ends at bit 0.
    - set cnt=0 and idx++.
    - after the bit with idx=DATA_BITS-1 is taken → STOP.
  - STOP: on the tick where cnt reaches OVERSAMPLE-1:
    - rx_s=1 → DATA<=shift register, RDA=1 for the next clk cycle only, → IDLE.
    - rx_s=0 → FE=1 for the next clk cycle only, DATA unchanged, → BREAK.
  - BREAK: on a tick with rx_s=1 → IDLE. A held-low line produces exactly one FE and no spurious frames.
- Outputs are registered: RDA/FE assert the clk cycle after the deciding tick. The next start bit can be detected on the very next tick after returning to IDLE, so back-to-back frames need no idle gap.
- Enable stuck high (tick every clk) is legal; timing is then counted in clk cycles.
- Enable=0 freezes the state and all counters. The synchroniser keeps running.
- RDA and FE are never both 1. No overrun detection: the consumer must take DATA on RDA before the next frame completes.
- Glitches shorter than OVERSAMPLE/2 ticks on an idle line must not start a frame.

Test Plan:
- Frame 0xA5, OVERSAMPLE=8, Enable=1 constantly. Drive RxD low 8 cycles, then bits 1,0,1,0,0,1,0,1 for 8 cycles each, then high → single RDA pulse, DATA=0xA5, FE stays 0.
- Real timing: Enable one pulse every 163 clk, byte 0x3C at 38400-baud bit width (1304 clk) → RDA once, DATA=0x3C, within one bit time after the stop-bit midpoint.
- Glitch: RxD low for 2 ticks on an idle line → no RDA, no FE, state returns to IDLE. A following frame 0x81 is received correctly.
- Framing error: after a good 0xA5, send 0x12 with the stop bit low and hold low 20 ticks, then release → exactly one FE pulse, no RDA, DATA remains 0xA5. The next frame 0x55 gives RDA with DATA=0x55.
- Back-to-back: 0x00 then 0xFF with no idle between the stop and start bits → two RDA pulses with DATA=0x00 then 0xFF.
- Reset mid-frame: assert rst during data bit 3 of 0x7E → DATA=0, RDA=0, FE=0. Resume with a complete frame 0x7E → RDA with DATA=0x7E.

Source files
------------

// File: rtl/spart_receive_if.sv
// rtl/spart_receive_if.sv - SPART receive front-end signal bundle
interface spart_receive_if #(
    parameter int DATA_BITS = 8
);
    logic                 Enable;
    logic                 RxD;
    logic [DATA_BITS-1:0] DATA;
    logic                 RDA;
    logic                 FE;

    modport master (output Enable, output RxD, input DATA, input RDA, input FE);
    modport slave  (input Enable, input RxD, output DATA, output RDA, output FE);
endinterface

// File: rtl/spart_receive.sv
// rtl/spart_receive.sv - SPART 8N1 serial receiver, oversampled on baud ticks
module spart_receive #(
    parameter int OVERSAMPLE = 8,
    parameter int DATA_BITS  = 8
) (
    input  logic            clk,
    input  logic            rst,
    spart_receive_if.slave  bus
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(OVERSAMPLE - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

    state_t               state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [IW-1:0]        idx, idx_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic [DATA_BITS-1:0] data_q, data_n;
    logic                 rda_q, rda_n;
    logic                 fe_q, fe_n;
    logic                 rx_m, rx_s;

    // Two-flop synchroniser runs every clk regardless of the baud tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= bus.RxD;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            idx    <= '0;
            shreg  <= '0;
            data_q <= '0;
            rda_q  <= 1'b0;
            fe_q   <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            idx    <= idx_n;
            shreg  <= shreg_n;
            data_q <= data_n;
            rda_q  <= rda_n;
            fe_q   <= fe_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        shreg_n = shreg;
        data_n  = data_q;
        rda_n   = 1'b0;
        fe_n    = 1'b0;
        if (bus.Enable) begin
            case (state)
                S_IDLE: begin
                    if (!rx_s) begin
                        state_n = S_START;
                        cnt_n   = '0;
                    end
                end
                S_START: begin
                    // Re-check the line half a bit in to reject short glitches.
                    if (cnt == HALF_LAST) begin
                        cnt_n = '0;
                        if (rx_s) begin
                            state_n = S_IDLE;
                        end else begin
                            state_n = S_DATA;
                            idx_n   = '0;
                        end
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                S_DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt_n   = '0;
                        shreg_n = {rx_s, shreg[DATA_BITS-1:1]};
                        if (idx == IDX_LAST) begin
                            idx_n   = '0;
                            state_n = S_STOP;
                        end else begin
                            idx_n = idx + IW'(1);
                        end
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                S_STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt_n = '0;
                        if (rx_s) begin
                            data_n  = shreg;
                            rda_n   = 1'b1;
                            state_n = S_IDLE;
                        end else begin
                            fe_n    = 1'b1;
                            state_n = S_BREAK;
                        end
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                S_BREAK: begin
                    if (rx_s) state_n = S_IDLE;
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    assign bus.DATA = data_q;
    assign bus.RDA  = rda_q;
    assign bus.FE   = fe_q;
endmodule
